spi_master_frame: RTL and testbench

//  Master-side SPI frame engine; the stage directly upstream of the SPI slave.

---
 rtl/spi_master_frame_pkg.sv | 18 +
 rtl/spi_master_frame_shift_reg.sv | 28 ++
 rtl/spi_master_frame.sv | 129 ++++++++++++
 tb/tb_spi_master_frame.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_frame_pkg.sv
// Shared types and defaults for the SPI master frame engine.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } spi_state_e;

    localparam int unsigned SPI_DATA_W_DEF  = 32;
    localparam int unsigned SPI_CS_IDLE_DEF = 2;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_master_frame_shift_reg.sv
// Parallel-load shift register, MSB leaves first, serial input enters at the LSB.
module spi_shift_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              sclk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_i,
    input  logic              ser_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge sclk_i) begin
        if (!reset_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= {data_q[DATA_W-2:0], ser_i};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/spi_master_frame.sv
// SPI master frame engine: valid/ready word in, MSB-first cs/mosi out, miso captured per frame.
module spi_master_frame
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = SPI_DATA_W_DEF,
    parameter int unsigned CS_IDLE = SPI_CS_IDLE_DEF
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned        CNT_W    = cnt_w(DATA_W);
    localparam int unsigned        GAP_CYC  = (CS_IDLE == 0) ? 1 : CS_IDLE;
    localparam logic [CNT_W-1:0]   BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(GAP_CYC - 1);

    spi_state_e        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  gap_cnt_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              cs_q;
    logic              mosi_q;

    logic              idle;
    logic              accept;
    logic              shift_en;
    logic              frame_active;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_word_d;

    assign idle         = (state_q == IDLE);
    assign accept       = idle && tx_valid;
    assign shift_en     = (state_q == SHIFT);
    assign frame_active = (state_q == LOAD) || (state_q == SHIFT);
    assign rx_word_d    = {rx_shift[DATA_W-2:0], miso};

    spi_shift_reg #(.DATA_W(DATA_W)) u_tx_shift (
        .sclk_i      (sclk),
        .reset_i     (reset),
        .load_i      (accept),
        .load_data_i (tx_data),
        .shift_i     (shift_en),
        .ser_i       (1'b0),
        .data_o      (tx_shift)
    );

    spi_shift_reg #(.DATA_W(DATA_W)) u_rx_shift (
        .sclk_i      (sclk),
        .reset_i     (reset),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (shift_en),
        .ser_i       (miso),
        .data_o      (rx_shift)
    );

    // Only the tx MSB drives mosi; the rx MSB falls off on the final capture shift.
    logic unused_bits;
    assign unused_bits = ^{tx_shift[DATA_W-2:0], rx_shift[DATA_W-1]};

    always_ff @(posedge sclk) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        bit_cnt_q <= '0;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        rx_data_q  <= rx_word_d;
                        rx_valid_q <= 1'b1;
                        gap_cnt_q  <= '0;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Launch on the falling edge so the slave sees stable cs/mosi at its rising edge.
    always_ff @(negedge sclk) begin
        if (!reset) begin
            cs_q   <= 1'b1;
            mosi_q <= 1'b0;
        end else begin
            cs_q   <= !frame_active;
            mosi_q <= frame_active ? tx_shift[DATA_W-1] : 1'b0;
        end
    end

    assign tx_ready = reset && idle;
    assign busy     = !idle;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign cs       = cs_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_frame.sv
// Randomised frame-level bench for spi_master_frame (32-bit/CS_IDLE=2 and 8-bit/CS_IDLE=0 instances).
module tb_spi_master_frame;

    logic        sclk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        loop_en;
    logic        miso_bit;
    logic        sel;

    logic        tx_ready_a, rx_valid_a, busy_a, cs_a, mosi_a, miso_a, tx_valid_a;
    logic [31:0] rx_data_a;
    logic        tx_ready_b, rx_valid_b, busy_b, cs_b, mosi_b, miso_b, tx_valid_b;
    logic [7:0]  rx_data_b;

    logic        tx_ready_m, rx_valid_m, busy_m, cs_m, mosi_m;
    logic [31:0] rx_data_m;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int prev_acc = -1;

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    assign tx_valid_a = tx_valid & ~sel;
    assign tx_valid_b = tx_valid & sel;
    assign miso_a     = loop_en ? mosi_a : miso_bit;
    assign miso_b     = loop_en ? mosi_b : miso_bit;

    assign tx_ready_m = sel ? tx_ready_b : tx_ready_a;
    assign rx_valid_m = sel ? rx_valid_b : rx_valid_a;
    assign busy_m     = sel ? busy_b     : busy_a;
    assign cs_m       = sel ? cs_b       : cs_a;
    assign mosi_m     = sel ? mosi_b     : mosi_a;
    assign rx_data_m  = sel ? {24'h0, rx_data_b} : rx_data_a;

    spi_master_frame #(.DATA_W(32), .CS_IDLE(2)) dut (
        .sclk     (sclk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid_a),
        .tx_ready (tx_ready_a),
        .rx_data  (rx_data_a),
        .rx_valid (rx_valid_a),
        .busy     (busy_a),
        .cs       (cs_a),
        .mosi     (mosi_a),
        .miso     (miso_a)
    );

    spi_master_frame #(.DATA_W(8), .CS_IDLE(0)) dut8 (
        .sclk     (sclk),
        .reset    (reset),
        .tx_data  (tx_data[7:0]),
        .tx_valid (tx_valid_b),
        .tx_ready (tx_ready_b),
        .rx_data  (rx_data_b),
        .rx_valid (rx_valid_b),
        .busy     (busy_b),
        .cs       (cs_b),
        .mosi     (mosi_b),
        .miso     (miso_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: one frame = setup cycle, W bits MSB first, then max(CS_IDLE,1) gap cycles.
    task automatic run_frame(input logic [31:0] w, input logic [31:0] m, input bit loop,
                             input bit wiggle, input bit hold, input string tag);
        int          nbits;
        int          gapn;
        int          n;
        int          rv;
        int          cs_hi;
        int          early_rdy;
        logic [31:0] got;
        logic [31:0] mask;
        logic [31:0] mv;
        nbits = sel ? 8 : 32;
        gapn  = sel ? 1 : 2;
        mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
        mv    = m;
        n = 0;
        while (tx_ready_m !== 1'b1 && n < 200) begin
            @(posedge sclk);
            #1;
            n++;
        end
        if (n >= 200) begin
            check({tag, "_ready_timeout"}, 32'(tx_ready_m), 32'h1);
            return;
        end
        tx_data  = w;
        tx_valid = 1'b1;
        loop_en  = loop;
        @(posedge sclk);
        #1;
        if (hold && prev_acc >= 0)
            check({tag, "_period"}, 32'(cyc - prev_acc), 32'(nbits + 2 + gapn));
        prev_acc = hold ? cyc : -1;
        check({tag, "_busy"}, {tx_ready_m, busy_m}, 32'h1);
        if (!hold) tx_valid = 1'b0;
        got = '0; rv = 0; cs_hi = 0;
        for (int k = 1; k <= nbits + 1; k++) begin
            @(negedge sclk);
            if (k >= 2) miso_bit = mv[nbits + 1 - k];
            if (wiggle) begin
                tx_valid = 1'($urandom);
                tx_data  = $urandom;
            end
            @(posedge sclk);
            if (k >= 2) got = {got[30:0], mosi_m};
            cs_hi += int'(cs_m);
            #1;
            if (k <= nbits) rv += int'(rx_valid_m);
        end
        if (wiggle) tx_valid = 1'b0;
        check({tag, "_mosi"}, got & mask, w & mask);
        check({tag, "_cs_low"}, 32'(cs_hi), 32'h0);
        check({tag, "_rv_early"}, 32'(rv), 32'h0);
        check({tag, "_rv"}, 32'(rx_valid_m), 32'h1);
        check({tag, "_rx"}, rx_data_m, (loop ? w : m) & mask);
        rv = 0; early_rdy = 0;
        for (int j = 1; j <= gapn; j++) begin
            @(posedge sclk);
            #1;
            rv += int'(rx_valid_m);
            if (j < gapn) early_rdy += int'(tx_ready_m);
        end
        check({tag, "_rv_single"}, 32'(rv), 32'h0);
        check({tag, "_rdy_early"}, 32'(early_rdy), 32'h0);
        check({tag, "_rdy_back"}, 32'(tx_ready_m), 32'h1);
    endtask

    initial begin
        sel = 1'b0; reset = 1'b0; tx_valid = 1'b1; tx_data = 32'hDEAD_BEEF;
        loop_en = 1'b0; miso_bit = 1'b0;

        repeat (3) @(posedge sclk);
        #1;
        check("rst_cs", 32'(cs_a), 32'h1);
        check("rst_mosi", 32'(mosi_a), 32'h0);
        check("rst_ready", 32'(tx_ready_a), 32'h0);
        check("rst_rv", 32'(rx_valid_a), 32'h0);
        check("rst_rx", rx_data_a, 32'h0);
        check("rst_cs8", 32'(cs_b), 32'h1);
        reset = 1'b1;
        tx_valid = 1'b0;
        #1;
        check("rel_ready", 32'(tx_ready_a), 32'h1);

        run_frame(32'hA5C3_0F81, 32'h0, 1'b1, 1'b0, 1'b0, "loopback");

        run_frame(32'h0000_0001, $urandom, 1'b0, 1'b0, 1'b1, "b2b_a");
        run_frame(32'hFFFF_FFFF, $urandom, 1'b0, 1'b0, 1'b1, "b2b_b");
        tx_valid = 1'b0;
        prev_acc = -1;

        // reset after 10 bits have been shifted
        tx_data = $urandom; tx_valid = 1'b1;
        @(posedge sclk);
        #1;
        tx_valid = 1'b0;
        repeat (11) @(posedge sclk);
        #1;
        reset = 1'b0;
        @(posedge sclk);
        #1;
        check("midrst_rv", 32'(rx_valid_a), 32'h0);
        check("midrst_rx", rx_data_a, 32'h0);
        check("midrst_busy", 32'(busy_a), 32'h0);
        @(negedge sclk);
        #1;
        check("midrst_cs", 32'(cs_a), 32'h1);
        check("midrst_mosi", 32'(mosi_a), 32'h0);
        @(posedge sclk);
        #1;
        reset = 1'b1;
        run_frame($urandom, $urandom, 1'b0, 1'b0, 1'b0, "after_rst");

        run_frame($urandom, $urandom, 1'b0, 1'b1, 1'b0, "wiggle_a");
        run_frame($urandom, $urandom, 1'b0, 1'b1, 1'b0, "wiggle_b");
        for (int i = 0; i < 4; i++)
            run_frame($urandom, $urandom, 1'($urandom), 1'b0, 1'b0, "rand32");

        sel = 1'b1;
        run_frame(32'h0000_003C, $urandom, 1'b0, 1'b0, 1'b0, "w8_3c");
        run_frame($urandom, $urandom, 1'b0, 1'b0, 1'b1, "w8_b2b_a");
        run_frame($urandom, $urandom, 1'b0, 1'b0, 1'b1, "w8_b2b_b");
        tx_valid = 1'b0;
        prev_acc = -1;
        for (int i = 0; i < 3; i++)
            run_frame($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0, "rand8");

        repeat (4) @(posedge sclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
